// File: rtl/cam_rx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : cam_rx_pkt_buf
// Purpose  : Paged camera RX packet buffer. Slices the byte stream into pages,
//            queues them FIFO-style and serves the oldest page to the CSR side.
// Options  : CAM_RX_PKT_BUF_OVERWRITE_EN - reuse the oldest ready page when
//            no free page is available, instead of dropping new data.
// Revision : 1.0 - initial release
// ============================================================================
module cam_rx_pkt_buf #(
    parameter int PAGE_NUM = 4,
    parameter int PAGE_AW  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    input  logic        wr_sof,
    input  logic        wr_eof,
    input  logic [7:0]  pkt_size,
    input  logic [7:0]  rx_ram_rd_addr,
    input  logic        rx_ram_rd_done,
    input  logic        rx_clean_all,
    output logic [7:0]  rx_ram_rd_byte,
    output logic [15:0] rx_ram_rd_flags,
    output logic        rx_ram_lost,
    output logic        rx_pending
);

    localparam int             c_CNT_W   = PAGE_AW + 1;
    localparam logic [1:0]     c_IDLE    = 2'd0;
    localparam logic [1:0]     c_FILL    = 2'd1;
    localparam logic [1:0]     c_DROP    = 2'd2;
    localparam logic [PAGE_AW-1:0] c_PTR_ONE = PAGE_AW'(1);

    logic [1:0]         r_state;
    logic [PAGE_AW-1:0] r_page;
    logic [7:0]         r_idx;
    logic [7:0]         r_lim;
    logic               r_sof;
    logic [4:0]         r_seq;

    logic [PAGE_AW-1:0] r_free [PAGE_NUM];
    logic [PAGE_AW-1:0] r_free_rd;
    logic [PAGE_AW-1:0] r_free_wr;
    logic [c_CNT_W-1:0] r_free_cnt;
    logic [PAGE_AW-1:0] r_rdy [PAGE_NUM];
    logic [PAGE_AW-1:0] r_rdy_rd;
    logic [PAGE_AW-1:0] r_rdy_wr;
    logic [c_CNT_W-1:0] r_rdy_cnt;

    logic [7:0]         r_mem [PAGE_NUM*256];
    logic [15:0]        r_flags [PAGE_NUM];

    logic [7:0]         r_rd_byte;
    logic [15:0]        r_rd_flags;
    logic               r_lost;
    logic               r_pending;

    logic               w_rdy_any;
    logic               w_have_free;
    logic [PAGE_AW-1:0] w_head;
    logic               w_restart;
    logic               w_close_fill;
    logic               w_start;
    logic               w_steal;
    logic               w_alloc;
    logic               w_lost;
    logic [PAGE_AW-1:0] w_alloc_page;
    logic               w_first_close;
    logic               w_push_b;
    logic               w_done;
    logic               w_rdy_pop;
    logic               w_free_pop;
    logic [4:0]         w_seq_b;
    logic [15:0]        w_flags_a;
    logic [15:0]        w_flags_b;
    logic [c_CNT_W-1:0] w_rdy_cnt_nxt;

    assign w_rdy_any    = (r_rdy_cnt != '0);
    assign w_have_free  = (r_free_cnt != '0);
    assign w_head       = r_rdy[r_rdy_rd];

    // A sof inside a page closes that page and restarts on the same byte.
    assign w_restart    = (r_state == c_FILL) && wr_valid && wr_sof && (r_idx != 8'd0);
    assign w_close_fill = (r_state == c_FILL) && wr_valid &&
                          (w_restart || (r_idx == r_lim) || wr_eof);
    assign w_start      = wr_valid && ((r_state == c_IDLE) || w_restart);

`ifdef CAM_RX_PKT_BUF_OVERWRITE_EN
    assign w_steal      = w_start && !w_have_free && w_rdy_any;
`else
    assign w_steal      = 1'b0;
`endif

    assign w_alloc       = w_start && (w_have_free || w_steal);
    assign w_lost        = w_start && !w_have_free;
    assign w_alloc_page  = w_have_free ? r_free[r_free_rd] : w_head;
    assign w_first_close = wr_eof || (pkt_size == 8'd0);
    // A single-byte page can close in the same cycle as a restart close.
    assign w_push_b      = w_alloc && w_first_close;
    assign w_done        = rx_ram_rd_done && w_rdy_any && !w_steal;
    assign w_rdy_pop     = w_done || w_steal;
    assign w_free_pop    = w_alloc && w_have_free;
    assign w_seq_b       = r_seq + 5'(w_close_fill);
    assign w_flags_a     = {r_seq, 1'b0, wr_eof && !w_restart, r_sof, r_idx};
    assign w_flags_b     = {w_seq_b, 1'b0, wr_eof, wr_sof, 8'd0};
    assign w_rdy_cnt_nxt = r_rdy_cnt + c_CNT_W'(w_close_fill) + c_CNT_W'(w_push_b)
                         - c_CNT_W'(w_rdy_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_page     <= '0;
            r_idx      <= 8'd0;
            r_lim      <= 8'd0;
            r_sof      <= 1'b0;
            r_seq      <= 5'd0;
            for (int i = 0; i < PAGE_NUM; i++) r_free[i] <= PAGE_AW'(i);
            r_free_rd  <= '0;
            r_free_wr  <= '0;
            r_free_cnt <= c_CNT_W'(PAGE_NUM);
            r_rdy_rd   <= '0;
            r_rdy_wr   <= '0;
            r_rdy_cnt  <= '0;
            r_rd_byte  <= 8'd0;
            r_rd_flags <= 16'd0;
            r_lost     <= 1'b0;
            r_pending  <= 1'b0;
        end else if (rx_clean_all) begin
            r_state    <= c_IDLE;
            r_page     <= '0;
            r_idx      <= 8'd0;
            r_lim      <= 8'd0;
            r_sof      <= 1'b0;
            r_seq      <= 5'd0;
            for (int i = 0; i < PAGE_NUM; i++) r_free[i] <= PAGE_AW'(i);
            r_free_rd  <= '0;
            r_free_wr  <= '0;
            r_free_cnt <= c_CNT_W'(PAGE_NUM);
            r_rdy_rd   <= '0;
            r_rdy_wr   <= '0;
            r_rdy_cnt  <= '0;
            r_rd_byte  <= 8'd0;
            r_rd_flags <= 16'd0;
            r_lost     <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (w_free_pop) r_free_rd <= r_free_rd + c_PTR_ONE;
            if (w_done) begin
                r_free[r_free_wr] <= w_head;
                r_free_wr         <= r_free_wr + c_PTR_ONE;
            end
            r_free_cnt <= r_free_cnt - c_CNT_W'(w_free_pop) + c_CNT_W'(w_done);

            if (w_rdy_pop) r_rdy_rd <= r_rdy_rd + c_PTR_ONE;
            r_rdy_wr   <= r_rdy_wr + PAGE_AW'(w_close_fill) + PAGE_AW'(w_push_b);
            r_rdy_cnt  <= w_rdy_cnt_nxt;
            r_seq      <= w_seq_b + 5'(w_push_b);

            r_lost     <= w_lost;
            r_pending  <= (w_rdy_cnt_nxt != '0);
            r_rd_byte  <= w_rdy_any ? r_mem[{w_head, rx_ram_rd_addr}] : 8'd0;
            r_rd_flags <= w_rdy_any ? r_flags[w_head] : 16'd0;

            if (w_start) begin
                r_lim  <= pkt_size;
                r_sof  <= wr_sof;
                r_idx  <= 8'd1;
                r_page <= w_alloc_page;
                if (w_first_close)
                    r_state <= c_IDLE;
                else if (w_alloc)
                    r_state <= c_FILL;
                else
                    r_state <= c_DROP;
            end else if (wr_valid && (r_state != c_IDLE)) begin
                if ((r_idx == r_lim) || wr_eof) r_state <= c_IDLE;
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Storage arrays carry no reset; queue pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_alloc)
            r_mem[{w_alloc_page, 8'd0}] <= wr_data;
        else if ((r_state == c_FILL) && wr_valid)
            r_mem[{r_page, r_idx}] <= wr_data;

        if (w_close_fill) begin
            r_flags[r_page]  <= w_flags_a;
            r_rdy[r_rdy_wr]  <= r_page;
        end
        if (w_push_b) begin
            r_flags[w_alloc_page] <= w_flags_b;
            r_rdy[w_close_fill ? (r_rdy_wr + c_PTR_ONE) : r_rdy_wr] <= w_alloc_page;
        end
    end

    assign rx_ram_rd_byte  = r_rd_byte;
    assign rx_ram_rd_flags = r_rd_flags;
    assign rx_ram_lost     = r_lost;
    assign rx_pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_cam_rx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_rx_pkt_buf
// Purpose  : Directed scenarios plus randomized traffic against a page-level
//            queue model of cam_rx_pkt_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_rx_pkt_buf;

    localparam int PAGE_NUM = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;
    logic        wr_sof = 1'b0;
    logic        wr_eof = 1'b0;
    logic [7:0]  pkt_size = 8'd3;
    logic [7:0]  rx_ram_rd_addr = 8'd0;
    logic        rx_ram_rd_done = 1'b0;
    logic        rx_clean_all = 1'b0;
    logic [7:0]  rx_ram_rd_byte;
    logic [15:0] rx_ram_rd_flags;
    logic        rx_ram_lost;
    logic        rx_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cam_rx_pkt_buf #(.PAGE_NUM(PAGE_NUM), .PAGE_AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_sof(wr_sof), .wr_eof(wr_eof), .pkt_size(pkt_size),
        .rx_ram_rd_addr(rx_ram_rd_addr), .rx_ram_rd_done(rx_ram_rd_done),
        .rx_clean_all(rx_clean_all), .rx_ram_rd_byte(rx_ram_rd_byte),
        .rx_ram_rd_flags(rx_ram_rd_flags), .rx_ram_lost(rx_ram_lost),
        .rx_pending(rx_pending)
    );

    // Reference model: page slots, ready/free queues, one open page.
    logic [7:0]  m_data [PAGE_NUM][256];
    logic [15:0] m_flag [PAGE_NUM];
    int          m_len  [PAGE_NUM];
    int          m_rdy[$];
    int          m_free[$];
    int          m_mode;           // 0 idle, 1 filling, 2 dropping
    int          m_slot, m_cnt, m_lim, m_seq;
    logic        m_sof;
    logic [7:0]  exp_byte;
    logic [15:0] exp_flags;
    logic        exp_lost, exp_pend, exp_byte_ok;

    task automatic m_reset();
        m_rdy.delete();
        m_free.delete();
        for (int i = 0; i < PAGE_NUM; i++) m_free.push_back(i);
        m_mode = 0; m_seq = 0; m_cnt = 0; m_lim = 0; m_slot = 0; m_sof = 1'b0;
    endtask

    task automatic m_close(input logic eof, input int n, input int len);
        m_flag[m_slot] = {5'(m_seq), 1'b0, eof, m_sof, 8'(n)};
        m_len[m_slot]  = len;
        m_rdy.push_back(m_slot);
        m_seq  = (m_seq + 1) % 32;
        m_mode = 0;
    endtask

    task automatic m_start();
        m_lim = int'(pkt_size);
        if (m_free.size() != 0) begin
            m_slot = m_free.pop_front();
            m_data[m_slot][0] = wr_data;
            m_sof = wr_sof;
            if (wr_eof || m_lim == 0) m_close(wr_eof, 0, 1);
            else begin m_mode = 1; m_cnt = 1; end
        end else begin
            exp_lost = 1'b1;
            if (wr_eof || m_lim == 0) m_mode = 0;
            else begin m_mode = 2; m_cnt = 1; end
        end
    endtask

    // Advance model and DUT by one clock; outputs are then sampled 1 ns later.
    task automatic tick();
        int freed;
        exp_lost    = 1'b0;
        exp_byte_ok = 1'b1;
        if (rx_clean_all || m_rdy.size() == 0) begin
            exp_byte = 8'd0; exp_flags = 16'd0;
        end else begin
            exp_flags   = m_flag[m_rdy[0]];
            exp_byte    = m_data[m_rdy[0]][rx_ram_rd_addr];
            exp_byte_ok = int'(rx_ram_rd_addr) < m_len[m_rdy[0]];
        end
        if (rx_clean_all) m_reset();
        else begin
            freed = -1;
            if (rx_ram_rd_done && m_rdy.size() != 0) freed = m_rdy.pop_front();
            if (wr_valid) begin
                if (m_mode == 1 && wr_sof) begin
                    m_close(1'b0, m_cnt, m_cnt);
                    m_start();
                end else if (m_mode == 1) begin
                    m_data[m_slot][m_cnt] = wr_data;
                    if (m_cnt == m_lim || wr_eof) m_close(wr_eof, m_cnt, m_cnt + 1);
                    else m_cnt++;
                end else if (m_mode == 2) begin
                    if (m_cnt == m_lim || wr_eof) m_mode = 0;
                    else m_cnt++;
                end else m_start();
            end
            if (freed >= 0) m_free.push_back(freed);
        end
        exp_pend = (m_rdy.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e);
        wr_data = d; wr_sof = s; wr_eof = e; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0;
    endtask

    task automatic pulse_done();
        rx_ram_rd_done = 1'b1;
        tick();
        rx_ram_rd_done = 1'b0;
    endtask

    task automatic clean();
        rx_clean_all = 1'b1;
        tick();
        rx_clean_all = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
        tick();
        checks++;
        if ({rx_ram_rd_byte, rx_ram_rd_flags, rx_ram_lost, rx_pending} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got byte=%h flags=%h lost=%b pend=%b want all 0",
                     rx_ram_rd_byte, rx_ram_rd_flags, rx_ram_lost, rx_pending);
        end
    endtask

    task automatic test_two_pages();
        pkt_size = 8'd3; rx_ram_rd_addr = 8'd0;
        for (int i = 0; i < 8; i++) put(8'h10 + 8'(i), 1'b0, 1'b0);
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0003) begin errors++;
            $display("FAIL two_pages_flags0: got %h want 0003", rx_ram_rd_flags); end
        for (int k = 0; k < 4; k++) begin
            rx_ram_rd_addr = 8'(k);
            tick();
            checks++;
            if (rx_ram_rd_byte !== 8'h10 + 8'(k)) begin errors++;
                $display("FAIL two_pages_byte0[%0d]: got %h want %h", k, rx_ram_rd_byte, 8'h10 + 8'(k)); end
        end
        pulse_done();
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0803) begin errors++;
            $display("FAIL two_pages_flags1: got %h want 0803", rx_ram_rd_flags); end
        for (int k = 0; k < 4; k++) begin
            rx_ram_rd_addr = 8'(k);
            tick();
            checks++;
            if (rx_ram_rd_byte !== 8'h14 + 8'(k)) begin errors++;
                $display("FAIL two_pages_byte1[%0d]: got %h want %h", k, rx_ram_rd_byte, 8'h14 + 8'(k)); end
        end
        checks++;
        if (rx_pending !== 1'b1) begin errors++;
            $display("FAIL two_pages_pend_before: got %b want 1", rx_pending); end
        pulse_done();
        checks++;
        if (rx_pending !== 1'b0) begin errors++;
            $display("FAIL two_pages_pend_after: got %b want 0", rx_pending); end
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0000) begin errors++;
            $display("FAIL two_pages_flags_empty: got %h want 0000", rx_ram_rd_flags); end
    endtask

    task automatic test_sof_eof();
        clean();
        pkt_size = 8'd249; rx_ram_rd_addr = 8'd0;
        put(8'hAA, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) put(8'hAA + 8'(i), 1'b0, 1'b0);
        checks++;
        if (rx_pending !== 1'b0) begin errors++;
            $display("FAIL sof_eof_pend_early: got %b want 0", rx_pending); end
        put(8'hAE, 1'b0, 1'b1);
        checks++;
        if (rx_pending !== 1'b1) begin errors++;
            $display("FAIL sof_eof_pend: got %b want 1", rx_pending); end
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0304) begin errors++;
            $display("FAIL sof_eof_flags: got %h want 0304", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'hAA) begin errors++;
            $display("FAIL sof_eof_byte0: got %h want aa", rx_ram_rd_byte); end
        pulse_done();
    endtask

    task automatic test_overflow();
        int lost_cnt;
        int lost_at;
        clean();
        pkt_size = 8'd3; rx_ram_rd_addr = 8'd0;
        lost_cnt = 0; lost_at = -1;
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < 4; k++) begin
                put(8'(p * 16 + k), 1'b0, 1'b0);
                if (rx_ram_lost) begin lost_cnt++; lost_at = p * 4 + k; end
            end
        checks++;
        if (lost_cnt != 1 || lost_at != 16) begin errors++;
            $display("FAIL overflow_lost: got %0d pulses at byte %0d want 1 at 16", lost_cnt, lost_at); end
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0003) begin errors++;
            $display("FAIL overflow_head_flags: got %h want 0003", rx_ram_rd_flags); end
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            checks++;
            if (rx_pending !== 1'b1) begin errors++;
                $display("FAIL overflow_pend[%0d]: got %b want 1", i, rx_pending); end
        end
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h1803) begin errors++;
            $display("FAIL overflow_last_flags: got %h want 1803", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'h30) begin errors++;
            $display("FAIL overflow_last_byte: got %h want 30", rx_ram_rd_byte); end
        pulse_done();
        checks++;
        if (rx_pending !== 1'b0) begin errors++;
            $display("FAIL overflow_drained: got %b want 0", rx_pending); end
    endtask

    task automatic test_sof_restart();
        clean();
        pkt_size = 8'd7; rx_ram_rd_addr = 8'd1;
        put(8'hB0, 1'b1, 1'b0);
        put(8'hB1, 1'b0, 1'b0);
        put(8'hB2, 1'b1, 1'b0);
        put(8'hB3, 1'b0, 1'b0);
        put(8'hB4, 1'b0, 1'b0);
        put(8'hB5, 1'b0, 1'b1);
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0102) begin errors++;
            $display("FAIL restart_old_flags: got %h want 0102", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'hB1) begin errors++;
            $display("FAIL restart_old_byte: got %h want b1", rx_ram_rd_byte); end
        pulse_done();
        rx_ram_rd_addr = 8'd0;
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0B03) begin errors++;
            $display("FAIL restart_new_flags: got %h want 0b03", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'hB2) begin errors++;
            $display("FAIL restart_new_byte: got %h want b2", rx_ram_rd_byte); end
        pulse_done();
    endtask

    task automatic test_clean_all();
        clean();
        pkt_size = 8'd1; rx_ram_rd_addr = 8'd0;
        for (int i = 0; i < 5; i++) put(8'h60 + 8'(i), 1'b0, 1'b0);
        checks++;
        if (rx_pending !== 1'b1) begin errors++;
            $display("FAIL clean_pend_before: got %b want 1", rx_pending); end
        wr_valid = 1'b1; wr_data = 8'h77;
        clean();
        wr_valid = 1'b0;
        checks++;
        if (rx_pending !== 1'b0 || rx_ram_lost !== 1'b0) begin errors++;
            $display("FAIL clean_after: got pend=%b lost=%b want 0 0", rx_pending, rx_ram_lost); end
        put(8'h55, 1'b0, 1'b0);
        put(8'h56, 1'b0, 1'b0);
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0001) begin errors++;
            $display("FAIL clean_new_flags: got %h want 0001", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'h55) begin errors++;
            $display("FAIL clean_new_byte: got %h want 55", rx_ram_rd_byte); end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        clean();
        pkt_size = 8'd1; rx_ram_rd_addr = 8'd1;
        put(8'hA0, 1'b0, 1'b0);
        put(8'hA1, 1'b0, 1'b0);
        put(8'hC0, 1'b0, 1'b0);
        rx_ram_rd_done = 1'b1;
        put(8'hC1, 1'b0, 1'b0);
        rx_ram_rd_done = 1'b0;
        checks++;
        if (rx_pending !== 1'b1) begin errors++;
            $display("FAIL b2b_pend: got %b want 1", rx_pending); end
        tick();
        checks++;
        if (rx_ram_rd_flags !== 16'h0801) begin errors++;
            $display("FAIL b2b_flags: got %h want 0801", rx_ram_rd_flags); end
        checks++;
        if (rx_ram_rd_byte !== 8'hC1) begin errors++;
            $display("FAIL b2b_byte: got %h want c1", rx_ram_rd_byte); end
        pulse_done();
    endtask

    task automatic test_random();
        clean();
        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 9) < 7);
            wr_data  = 8'($urandom);
            wr_sof   = ($urandom_range(0, 9) == 0);
            wr_eof   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 63) == 0) pkt_size = 8'd255;
            else if ($urandom_range(0, 7) == 0) pkt_size = 8'($urandom_range(0, 6));
            rx_ram_rd_done = ($urandom_range(0, 5) == 0);
            rx_clean_all   = ($urandom_range(0, 299) == 0);
            rx_ram_rd_addr = (m_rdy.size() != 0) ? 8'($urandom % m_len[m_rdy[0]]) : 8'($urandom);
            tick();
            checks++;
            if (rx_ram_lost !== exp_lost) begin errors++;
                $display("FAIL rand_lost @%0d: got %b want %b", i, rx_ram_lost, exp_lost); end
            checks++;
            if (rx_pending !== exp_pend) begin errors++;
                $display("FAIL rand_pend @%0d: got %b want %b", i, rx_pending, exp_pend); end
            checks++;
            if (rx_ram_rd_flags !== exp_flags) begin errors++;
                $display("FAIL rand_flags @%0d: got %h want %h", i, rx_ram_rd_flags, exp_flags); end
            if (exp_byte_ok) begin
                checks++;
                if (rx_ram_rd_byte !== exp_byte) begin errors++;
                    $display("FAIL rand_byte @%0d: got %h want %h", i, rx_ram_rd_byte, exp_byte); end
            end
        end
        wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0;
        rx_ram_rd_done = 1'b0; rx_clean_all = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_pages();
        test_sof_eof();
        test_overflow();
        test_sof_restart();
        test_clean_all();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
